// File: rtl/timer186_pkg.sv
// Shared constants for the wb_timer186 Wishbone timer:
// register word offsets, control bit positions, byte-lane merge helper.
package timer186_pkg;

   localparam logic [1:0] ADR_COUNT = 2'd0;
   localparam logic [1:0] ADR_MAXA  = 2'd1;
   localparam logic [1:0] ADR_MAXB  = 2'd2;
   localparam logic [1:0] ADR_CTRL  = 2'd3;

   localparam int CTL_EN   = 15;
   localparam int CTL_INH  = 14;
   localparam int CTL_INT  = 13;
   localparam int CTL_RIU  = 12;
   localparam int CTL_MC   = 5;
   localparam int CTL_ALT  = 1;
   localparam int CTL_CONT = 0;

   function automatic logic [15:0] lane_merge(
      input logic [15:0] old_v,
      input logic [15:0] wr_v,
      input logic [1:0]  sel
   );
      logic [15:0] r;
      r = old_v;
      if (sel[0]) r[7:0]  = wr_v[7:0];
      if (sel[1]) r[15:8] = wr_v[15:8];
      return r;
   endfunction

endpackage

// File: rtl/timer186_prescaler.sv
// Count-tick generator: one-clk tick every PRESCALE clocks while en is high.
// Held at zero while disabled, so every enable restarts the phase.
module timer186_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam logic [7:0] LAST = 8'(PRESCALE - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = 8'd0;
      if (en && !tick) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 8'd0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/wb_timer186.sv
// 80C186-style timer on a single-wait-state Wishbone slave port.
// Define WB_TIMER186_ALT_EN to build the dual max-count (ALT/RIU/max B) mode.
module wb_timer186
   import timer186_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [1:0]  wb_adr_i,
   input  logic [1:0]  wb_sel_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        irq,
   output logic        tout
);

   logic        ack_q, ack_d;
   logic [15:0] dat_q, dat_d;
   logic        irq_q, irq_d;
   logic        tout_q, tout_d;
   logic [15:0] count_q, count_d;
   logic [15:0] maxa_q, maxa_d;
   logic        en_q, en_d;
   logic        inh_q, inh_d;
   logic        intr_q, intr_d;
   logic        mc_q, mc_d;
   logic        cont_q, cont_d;

   logic        alt, riu;
   logic [15:0] max_b;

`ifdef WB_TIMER186_ALT_EN
   logic        alt_q, alt_d;
   logic        riu_q, riu_d;
   logic [15:0] maxb_q, maxb_d;
   assign alt   = alt_q;
   assign riu   = riu_q;
   assign max_b = maxb_q;
`else
   assign alt   = 1'b0;
   assign riu   = 1'b0;
   assign max_b = 16'd0;
`endif

   logic        tick, req, wr, cnt_wr, term;
   logic [15:0] nxt, max_act, ctrl_w;

   timer186_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en_q),
      .tick (tick)
   );

   assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wr      = req & wb_we_i;
   assign cnt_wr  = wr & (wb_adr_i == ADR_COUNT) & (|wb_sel_i);
   assign nxt     = count_q + 16'd1;
   assign max_act = riu ? max_b : maxa_q;
   // A count write in the same cycle swallows the tick entirely.
   assign term    = tick & ~cnt_wr & (nxt == max_act);
   assign ctrl_w  = {en_q, inh_q, intr_q, riu, 6'd0, mc_q, 3'd0, alt, cont_q};

   always_comb begin
      ack_d   = req;
      dat_d   = 16'd0;
      irq_d   = 1'b0;
      count_d = count_q;
      maxa_d  = maxa_q;
      en_d    = en_q;
      inh_d   = inh_q;
      intr_d  = intr_q;
      mc_d    = mc_q;
      cont_d  = cont_q;
`ifdef WB_TIMER186_ALT_EN
      alt_d   = alt_q;
      riu_d   = riu_q;
      maxb_d  = maxb_q;
`endif
      if (req) begin
         unique case (wb_adr_i)
            ADR_COUNT: dat_d = count_q;
            ADR_MAXA:  dat_d = maxa_q;
            ADR_MAXB:  dat_d = max_b;
            ADR_CTRL:  dat_d = ctrl_w;
         endcase
      end
      if (tick && !cnt_wr) count_d = term ? 16'd0 : nxt;
      if (term) begin
         mc_d  = 1'b1;
         irq_d = intr_q;
`ifdef WB_TIMER186_ALT_EN
         if (alt_q) riu_d = ~riu_q;
`endif
         if (!cont_q && (!alt || riu)) en_d = 1'b0;
      end
      if (wr) begin
         unique case (wb_adr_i)
            ADR_COUNT: count_d = lane_merge(count_q, wb_dat_i, wb_sel_i);
            ADR_MAXA:  maxa_d  = lane_merge(maxa_q, wb_dat_i, wb_sel_i);
            ADR_MAXB: begin
`ifdef WB_TIMER186_ALT_EN
               maxb_d = lane_merge(maxb_q, wb_dat_i, wb_sel_i);
`endif
            end
            ADR_CTRL: begin
               if (wb_sel_i[1]) begin
                  inh_d  = wb_dat_i[CTL_INH];
                  intr_d = wb_dat_i[CTL_INT];
                  if (wb_dat_i[CTL_INH]) en_d = wb_dat_i[CTL_EN];
               end
               if (wb_sel_i[0]) begin
                  // A coinciding terminal event keeps MC set.
                  if (!wb_dat_i[CTL_MC] && !term) mc_d = 1'b0;
                  cont_d = wb_dat_i[CTL_CONT];
`ifdef WB_TIMER186_ALT_EN
                  alt_d  = wb_dat_i[CTL_ALT];
`endif
               end
            end
         endcase
      end
`ifdef WB_TIMER186_ALT_EN
      tout_d = alt_d ? ~riu_d : ~term;
`else
      tout_d = ~term;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q   <= 1'b0;
         dat_q   <= 16'd0;
         irq_q   <= 1'b0;
         tout_q  <= 1'b1;
         count_q <= 16'd0;
         maxa_q  <= 16'd0;
         en_q    <= 1'b0;
         inh_q   <= 1'b0;
         intr_q  <= 1'b0;
         mc_q    <= 1'b0;
         cont_q  <= 1'b0;
`ifdef WB_TIMER186_ALT_EN
         alt_q   <= 1'b0;
         riu_q   <= 1'b0;
         maxb_q  <= 16'd0;
`endif
      end else begin
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         irq_q   <= irq_d;
         tout_q  <= tout_d;
         count_q <= count_d;
         maxa_q  <= maxa_d;
         en_q    <= en_d;
         inh_q   <= inh_d;
         intr_q  <= intr_d;
         mc_q    <= mc_d;
         cont_q  <= cont_d;
`ifdef WB_TIMER186_ALT_EN
         alt_q   <= alt_d;
         riu_q   <= riu_d;
         maxb_q  <= maxb_d;
`endif
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign irq      = irq_q;
   assign tout     = tout_q;

endmodule

// File: tb/tb_wb_timer186.sv
// Scoreboard bench for wb_timer186: reads queue expected data, a monitor
// pops and compares on each read ack; irq/tout events are logged by cycle.
module tb_wb_timer186;
   import timer186_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [1:0]  adr = 2'd0, sel = 2'd0;
   logic [15:0] dat_i = 16'd0;
   logic [15:0] dat_o;
   logic        ack, irq, tout;

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;
   int wc = 0;
   int w0 = 0;
   int irq_log[$];
   int tout_log[$];

   typedef struct {
      string       name;
      logic [15:0] val;
   } exp_t;
   exp_t sb[$];

   wb_timer186 #(.PRESCALE(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wb_cyc_i(cyc),
      .wb_stb_i(stb),
      .wb_we_i (we),
      .wb_adr_i(adr),
      .wb_sel_i(sel),
      .wb_dat_i(dat_i),
      .wb_dat_o(dat_o),
      .wb_ack_o(ack),
      .irq     (irq),
      .tout    (tout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_n++;

   always @(negedge clk) begin
      if (irq)   irq_log.push_back(cyc_n);
      if (!tout) tout_log.push_back(cyc_n);
   end

   // Monitor: every read ack is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (ack && !we) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_read got=%h", dat_o);
         end else begin
            e = sb.pop_front();
            if (dat_o !== e.val) begin
               failures++;
               $display("FAIL %s got=%h want=%h", e.name, dat_o, e.val);
            end
         end
      end
   end

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", n, act, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [1:0] a,
                      input logic [15:0] d, input logic [1:0] s);
      @(posedge clk);
      #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      @(posedge clk);
      #1;
      wc = cyc_n;
      chk("ack_timing", int'(ack), 1);
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      bus(1'b1, a, d, 2'b11);
   endtask

   task automatic rd(input logic [1:0] a, input logic [15:0] e,
                     input string n);
      sb.push_back('{n, e});
      bus(1'b0, a, 16'd0, 2'b11);
   endtask

   function automatic int at(input int q[$], input int k);
      return (q.size() > k) ? q[k] : -1;
   endfunction

   initial begin
      int errs;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tout", int'(tout), 1);
      chk("rst_irq", int'(irq), 0);
      rst_n = 1'b1;
      rd(ADR_COUNT, 16'h0000, "rst_count");
      rd(ADR_MAXA,  16'h0000, "rst_maxa");
      rd(ADR_MAXB,  16'h0000, "rst_maxb");
      rd(ADR_CTRL,  16'h0000, "rst_ctrl");

      // single shot
      irq_log.delete(); tout_log.delete();
      wr(ADR_MAXA, 16'd3);
      wr(ADR_CTRL, 16'hE000);
      w0 = wc;
      repeat (14) @(posedge clk);
      chk("ss_irq_n", irq_log.size(), 1);
      chk("ss_irq_t", at(irq_log, 0), w0 + 12);
      chk("ss_tout_n", tout_log.size(), 1);
      chk("ss_tout_t", at(tout_log, 0), w0 + 12);
      rd(ADR_COUNT, 16'h0000, "ss_count");
      rd(ADR_CTRL,  16'h6020, "ss_ctrl");

      // continuous
      irq_log.delete();
      wr(ADR_MAXA, 16'd2);
      wr(ADR_CTRL, 16'hE001);
      w0 = wc;
      repeat (25) @(posedge clk);
      chk("cont_irq_n", irq_log.size(), 3);
      for (int k = 0; k < 3; k++)
         chk("cont_irq_t", at(irq_log, k), w0 + 8 * (k + 1));
      wr(ADR_CTRL, 16'h0001);
      rd(ADR_CTRL, 16'h8001, "cont_inh0");
      repeat (8) @(posedge clk);
      rd(ADR_CTRL, 16'h8021, "cont_running");
      wr(ADR_CTRL, 16'h4000);
      chk("cont_irq_masked", irq_log.size(), 3);

      // boundary: max 0 means 65536
      irq_log.delete();
      wr(ADR_MAXA, 16'd0);
      wr(ADR_COUNT, 16'hFFFE);
      wr(ADR_CTRL, 16'hE000);
      w0 = wc;
      repeat (10) @(posedge clk);
      chk("max0_irq_n", irq_log.size(), 1);
      chk("max0_irq_t", at(irq_log, 0), w0 + 8);
      rd(ADR_COUNT, 16'h0000, "max0_count");
      rd(ADR_CTRL,  16'h6020, "max0_ctrl");

      // count write landing exactly on a tick
      wr(ADR_CTRL, 16'hC001);
      w0 = wc;
      repeat (6) @(posedge clk);
      wr(ADR_COUNT, 16'h1234);
      chk("collide_cycle", wc, w0 + 8);
      rd(ADR_COUNT, 16'h1234, "collide_count");
      wr(ADR_CTRL, 16'h4000);

      // byte lanes and MC behaviour
      bus(1'b1, ADR_MAXA, 16'hABCD, 2'b01);
      rd(ADR_MAXA, 16'h00CD, "lane_lo");
      wr(ADR_MAXA, 16'd1);
      wr(ADR_COUNT, 16'd0);
      wr(ADR_CTRL, 16'hC000);
      repeat (6) @(posedge clk);
      rd(ADR_CTRL, 16'h4020, "mc_set");
      wr(ADR_CTRL, 16'h4020);
      rd(ADR_CTRL, 16'h4020, "mc_write1");
      wr(ADR_CTRL, 16'h4000);
      rd(ADR_CTRL, 16'h4000, "mc_write0");
      bus(1'b1, ADR_COUNT, 16'hFFFF, 2'b00);
      rd(ADR_COUNT, 16'h0000, "sel00");

      // reset mid-count aborts without irq
      wr(ADR_MAXA, 16'd3);
      wr(ADR_CTRL, 16'hE000);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      irq_log.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      chk("rst_mid_irq", irq_log.size(), 0);
      chk("rst_mid_tout", int'(tout), 1);
      rd(ADR_CTRL, 16'h0000, "rst_mid_ctrl");
      rd(ADR_MAXA, 16'h0000, "rst_mid_maxa");

`ifdef WB_TIMER186_ALT_EN
      irq_log.delete();
      wr(ADR_MAXA, 16'd2);
      wr(ADR_MAXB, 16'd3);
      rd(ADR_MAXB, 16'd3, "alt_maxb");
      wr(ADR_CTRL, 16'hE003);
      errs = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (tout !== ((k < 8) ? 1'b1 : (k < 20) ? 1'b0 :
                       (k < 28) ? 1'b1 : 1'b0)) errs++;
      end
      chk("alt_tout_errs", errs, 0);
      chk("alt_irq_n", irq_log.size(), 3);
      rd(ADR_CTRL, 16'hE023, "alt_ctrl");
      wr(ADR_CTRL, 16'h4000);
`else
      errs = 0;
      wr(ADR_MAXB, 16'h1234);
      rd(ADR_MAXB, 16'h0000, "maxb_absent");
      wr(ADR_CTRL, 16'h0003);
      rd(ADR_CTRL, 16'h0001, "alt_tied");
      chk("noalt_errs", errs, 0);
`endif

      repeat (2) @(posedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
